press_bit_serializer: RTL and testbench
=======================================

// Module: press_bit_serializer
// PURPOSE
//  Sits between the read-button debouncer and the Moore sequence-detector FSM.
//  Converts each press of the debounced read level into exactly one serial bit of a latched 8-bit word, MSB first.
//  Each bit is presented with a one-cycle bit_valid strobe, so the FSM advances once per press, never once per held cycle.
//  Reports progress through the word and completion of the word.
// PARAMETERS
//  WIDTH        8  bits per word
//  SYNC_STAGES  2  flops in the read_level synchronizer (>=2)
//  MSB_FIRST    1  1: emit word[WIDTH-1] first; 0: emit word[0] first
// PORTS
//  clk         in   1                    system clock; all state on rising edge
//  reset       in   1                    asynchronous, active-low; clears all state
//  read_level  in   1                    debounced read button level (may be asynchronous to clk)
//  clear       in   1                    synchronous abort of the current word
//  word_in     in   WIDTH                word sampled at the first press of a word
//  bit_out     out  1                    current serial bit; held between strobes
//  bit_valid   out  1                    1-cycle strobe: bit_out is new this cycle
//  busy        out  1                    high while a word is partially emitted
//  done        out  1                    1-cycle strobe coincident with the last bit_valid of a word
//  bit_index   out  $clog2(WIDTH+1)      bits emitted so far in the current word
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; shift register 0; arm flag 0.
//  Press detect:
//   - read_level passes through SYNC_STAGES flops, then a rising-edge detector.
//   - press = sync_level & ~prev_level & armed.
//   - armed sets the first cycle sync_level is 0 after reset. A level held high through reset release produces no press.
//  Latency: bit_valid rises SYNC_STAGES+1 clk edges after the first edge that samples read_level=1.
//  State IDLE:
//   - On press: load word_in into sreg and drive bit_out = selected end bit.
//   - Same cycle: bit_valid=1, bit_index=1, busy=1; go to SHIFT.
//   - With WIDTH==1: done=1, busy=0; stay in IDLE.
//  State SHIFT:
//   - On press: shift sreg, drive the next bit, bit_valid=1, bit_index+1.
//   - When bit_index reaches WIDTH: done=1 that cycle, busy=0, bit_index returns to 0 the next cycle, go to IDLE.
//  Held level: one press per rising edge only. Holding read_level high emits one bit.
//  word_in changes while busy are ignored until the next word loads.
//  clear=1: next cycle IDLE, busy=0, bit_index=0, no strobes. bit_out keeps its value.
//  clear and press in the same cycle: clear wins and the press is discarded.
//  reset asserted mid-word: immediate return to the reset values. The partial word is lost.
//  bit_valid/done never assert without a press. Strobes are never back-to-back, since presses are at least 2 cycles apart.
// STRUCTURE
//  Shared package: state encoding ST_IDLE=1'b0, ST_SHIFT=1'b1; the index width function.
//  Sub-module press_edge_sync: synchronizer + prev flop + arm flag.
//   - ports: clk, reset, level_in, press_out; parameter SYNC_STAGES.
//  Top level: FSM, WIDTH-bit shift register, index counter, registered outputs.
// TESTING
//  1. word_in=8'b10110111; 8 presses, 160ns high / 100ns low:
//     - bit_out sequence 1,0,1,1,0,1,1,1; one bit_valid per press;
//     - done with the 8th bit; bit_index 1..8 then 0.
//  2. read_level held high for 50 cycles -> exactly one bit_valid; bit_index=1.
//  3. read_level=1 while reset=0, then release reset with the level still high -> no bit_valid until the level falls and rises again.
//  4. word_in changed to 8'h00 after the 3rd press -> bits 4..8 still 1,0,1,1,1.
//  5. clear pulsed after the 5th press, then 8 presses with word_in=8'hA5 -> 1,0,1,0,0,1,0,1; done on the 8th.
//  6. reset low mid-word (after the 4th bit) -> all outputs 0 asynchronously; the next press loads a fresh word with bit_index=1.
//  7. MSB_FIRST=0 with 8'b10110111 -> 1,1,1,0,1,1,0,1.

Source files
------------

// File: rtl/press_bit_serializer_pkg.sv
// Shared types for the press-driven bit serializer: FSM state encoding and
// the helper that sizes the bit index counter.
package press_bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int idx_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/press_edge_sync.sv
// Synchronizes the debounced read level and turns each rising edge into a
// single-cycle press, suppressed until the level has been seen low once.
module press_edge_sync
    import press_bit_serializer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic press_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_level;
    logic                   armed;
    logic                   sync_level;

    assign sync_level = sync_q[SYNC_STAGES-1];

    // fill_q marks when sync_level holds a real sample rather than the reset
    // zeros, so a level held high through reset release cannot arm the detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            fill_q     <= '0;
            prev_level <= 1'b0;
            armed      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], level_in};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_level <= sync_level;
            if (fill_q[SYNC_STAGES-1] && !sync_level) begin
                armed <= 1'b1;
            end
        end
    end

    assign press_out = sync_level & ~prev_level & armed;

endmodule

// File: rtl/press_bit_serializer.sv
// Emits one bit of a latched word per button press, with a one-cycle
// bit_valid strobe, progress index and end-of-word done strobe.
module press_bit_serializer
    import press_bit_serializer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read_level,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               word_in,
    output logic                           bit_out,
    output logic                           bit_valid,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(WIDTH+1)-1:0]     bit_index
);

    localparam int IW = idx_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic             press;

    press_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk      (clk),
        .reset    (reset),
        .level_in (read_level),
        .press_out(press)
    );

    // The emitted bit always sits at the selected end of the register.
    always_comb begin
        shifted = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_index <= '0;
        end else begin
            bit_valid <= 1'b0;
            done      <= 1'b0;
            if (clear) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                bit_index <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press) begin
                            sreg      <= word_in;
                            bit_out   <= MSB_FIRST ? word_in[WIDTH-1] : word_in[0];
                            bit_valid <= 1'b1;
                            bit_index <= IW'(1);
                            if (WIDTH == 1) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end else begin
                                busy  <= 1'b1;
                                state <= ST_SHIFT;
                            end
                        end else begin
                            bit_index <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (press) begin
                            sreg      <= shifted;
                            bit_out   <= MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
                            bit_valid <= 1'b1;
                            bit_index <= bit_index + IW'(1);
                            if (bit_index == IW'(WIDTH - 1)) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_press_bit_serializer.sv
// Self-checking bench for press_bit_serializer: MSB-first and LSB-first
// instances share stimulus; table vectors, corner sequences, random presses.
module tb_press_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       read_level;
    logic       clear;
    logic [7:0] word_in;

    logic       bo_m, bv_m, bz_m, dn_m;
    logic [3:0] bi_m;
    logic       bo_l, bv_l, bz_l, dn_l;
    logic [3:0] bi_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    press_bit_serializer #(.WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(rst_n), .read_level(read_level), .clear(clear),
        .word_in(word_in), .bit_out(bo_m), .bit_valid(bv_m), .busy(bz_m),
        .done(dn_m), .bit_index(bi_m)
    );

    press_bit_serializer #(.WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(rst_n), .read_level(read_level), .clear(clear),
        .word_in(word_in), .bit_out(bo_l), .bit_valid(bv_l), .busy(bz_l),
        .done(dn_l), .bit_index(bi_l)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: a word is latched at its first press and its bits are
    // handed out in order, one per press.
    logic [7:0] m_word;
    int         m_count = 0;

    task automatic model_press(output int xm, output int xl, output int xidx, output int xdn);
        if (m_count == 0) m_word = word_in;
        xm = m_word[7 - m_count];
        xl = m_word[m_count];
        m_count++;
        xidx = m_count;
        xdn  = (m_count == 8) ? 1 : 0;
        if (m_count == 8) m_count = 0;
    endtask

    task automatic run_press(input int hi, input int lo, input bit clr,
                             output int ns_m, output int ns_l, output int lat,
                             output int bm, output int bl, output int idx,
                             output int dn, output int bz,
                             output int end_idx, output int end_bz);
        ns_m = 0; ns_l = 0; lat = -1; bm = -1; bl = -1; idx = -1; dn = 0; bz = -1;
        read_level = 1'b1;
        for (int c = 1; c <= hi + lo; c++) begin
            @(negedge clk);
            if (bv_m) begin
                ns_m++; lat = c; bm = bo_m; idx = bi_m; bz = bz_m;
            end
            if (bv_l) begin
                ns_l++; bl = bo_l;
            end
            if (dn_m) dn++;
            if (c == hi) read_level = 1'b0;
            if (clr && c == 2) clear = 1'b1;
            if (c == 3) clear = 1'b0;
        end
        end_idx = bi_m;
        end_bz  = bz_m;
    endtask

    task automatic checked_press(input string tag, input int hi, input int lo,
                                 input int xm, input int xl, input int xidx, input int xdn);
        int ns_m, ns_l, lat, bm, bl, idx, dn, bz, end_idx, end_bz;
        run_press(hi, lo, 1'b0, ns_m, ns_l, lat, bm, bl, idx, dn, bz, end_idx, end_bz);
        check({tag, "/strobes_msb"}, ns_m, 1);
        check({tag, "/strobes_lsb"}, ns_l, 1);
        check({tag, "/latency"}, lat, 3);
        check({tag, "/bit_msb"}, bm, xm);
        check({tag, "/bit_lsb"}, bl, xl);
        check({tag, "/bit_index"}, idx, xidx);
        check({tag, "/done"}, dn, xdn);
        check({tag, "/busy"}, bz, (xdn != 0) ? 0 : 1);
        check({tag, "/end_index"}, end_idx, (xdn != 0) ? 0 : xidx);
    endtask

    task automatic model_checked_press(input string tag, input int hi, input int lo);
        int xm, xl, xidx, xdn;
        model_press(xm, xl, xidx, xdn);
        checked_press(tag, hi, lo, xm, xl, xidx, xdn);
    endtask

    task automatic clear_pulse(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        check({tag, "/clr_busy"}, bz_m, 0);
        check({tag, "/clr_index"}, bi_m, 0);
    endtask

    typedef struct {
        logic [7:0] word;
        bit         clr;
        int         xm;
        int         xl;
        int         xidx;
        int         xdn;
    } vec_t;

    vec_t tbl[29];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq_b7_msb;
        logic [7:0] seq_b7_lsb;
        logic [7:0] seq_a5;
        int ns_m, ns_l, lat, bm, bl, idx, dn, bz, end_idx, end_bz, cnt;

        // Expected serial sequences, first emitted bit in position 7.
        seq_b7_msb = 8'b10110111;
        seq_b7_lsb = 8'b11101101;
        seq_a5     = 8'b10100101;
        for (int k = 0; k < 8; k++) begin
            tbl[k] = '{8'hB7, 1'b0, int'(seq_b7_msb[7-k]), int'(seq_b7_lsb[7-k]), k + 1, (k == 7) ? 1 : 0};
            tbl[8+k] = '{(k < 3) ? 8'hB7 : 8'h00, 1'b0, int'(seq_b7_msb[7-k]), int'(seq_b7_lsb[7-k]),
                         k + 1, (k == 7) ? 1 : 0};
            tbl[21+k] = '{8'hA5, (k == 0), int'(seq_a5[7-k]), int'(seq_a5[7-k]), k + 1, (k == 7) ? 1 : 0};
        end
        for (int k = 0; k < 5; k++) begin
            tbl[16+k] = '{8'hB7, 1'b0, int'(seq_b7_msb[7-k]), int'(seq_b7_lsb[7-k]), k + 1, 0};
        end

        rst_n = 1'b0; read_level = 1'b0; clear = 1'b0; word_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset/bit_out", bo_m, 0);
        check("reset/bit_valid", bv_m, 0);
        check("reset/busy", bz_m, 0);
        check("reset/done", dn_m, 0);
        check("reset/bit_index", bi_m, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 29; i++) begin
            int xm, xl, xidx, xdn;
            if (tbl[i].clr) clear_pulse("table");
            word_in = tbl[i].word;
            model_press(xm, xl, xidx, xdn);
            checked_press($sformatf("table%0d", i), 16, 10, tbl[i].xm, tbl[i].xl, tbl[i].xidx, tbl[i].xdn);
        end

        // Held level: one bit only.
        word_in = 8'hB7;
        model_checked_press("held", 50, 5);
        clear_pulse("held");

        // Level high across reset release must not count as a press.
        @(negedge clk);
        rst_n = 1'b0;
        read_level = 1'b1;
        m_count = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cnt += int'(bv_m) + int'(bv_l);
        end
        check("held_reset/no_strobe", cnt, 0);
        read_level = 1'b0;
        repeat (6) @(negedge clk);
        model_checked_press("held_reset/first", 4, 4);
        clear_pulse("held_reset");

        // Asynchronous reset in the middle of a word.
        word_in = 8'hB7;
        for (int i = 0; i < 4; i++) model_checked_press($sformatf("midrst%0d", i), 4, 4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/bit_out", bo_m, 0);
        check("midrst/busy", bz_m, 0);
        check("midrst/bit_index", bi_m, 0);
        check("midrst/busy_lsb", bz_l, 0);
        m_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        word_in = 8'hA5;
        model_checked_press("midrst/fresh", 4, 4);

        // Clear coincident with a press: the press is dropped.
        model_checked_press("clrpress/pre", 4, 4);
        run_press(4, 4, 1'b1, ns_m, ns_l, lat, bm, bl, idx, dn, bz, end_idx, end_bz);
        check("clrpress/strobes_msb", ns_m, 0);
        check("clrpress/strobes_lsb", ns_l, 0);
        check("clrpress/done", dn, 0);
        check("clrpress/busy", end_bz, 0);
        check("clrpress/bit_index", end_idx, 0);
        m_count = 0;
        word_in = 8'h3C;
        model_checked_press("clrpress/fresh", 4, 4);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) clear_pulse("rand");
            word_in = 8'($urandom);
            model_checked_press($sformatf("rand%0d", i), int'($urandom_range(1, 6)), int'($urandom_range(3, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
